boot_run_ctrl: RTL and testbench

- Synthesizable successor to the core bench's load/reset/timed-stop sequence.
- Streams a program into the core's instruction memory through a valid/ready port.
- Holds the core in reset for a programmable number of cycles, then runs it until a halt indication or a cycle-budget timeout.
- Sits between the host/UART loader and the riscv core top; drives the core's active-high reset.

---
 rtl/boot_run_ctrl.sv | 99 +++++++++
 tb/tb_boot_run_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/boot_run_ctrl.sv
// boot_run_ctrl: streams a program into imem, holds the core in reset, then runs it until halt or budget timeout
module boot_run_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int RST_HOLD = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reload,
  input  logic [CNT_W-1:0]  budget,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst,
  input  logic              halt,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [ADDR_W:0]   load_count,
  output logic [CNT_W-1:0]  run_cycles
);
  localparam int HW = $clog2(RST_HOLD + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_load_count;
  logic [CNT_W-1:0]  r_run_cycles, r_budget, w_rc_inc;
  logic [HW-1:0]     r_hold;
  logic              r_overflow, r_timeout;
  logic              w_go, w_acc, w_end_addr, w_hold_end, w_tmo;
  assign w_go       = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_acc      = s_valid && r_state == S_LOAD;
  assign w_end_addr = &r_addr;
  assign w_hold_end = r_hold == HW'(RST_HOLD - 1);
  assign w_rc_inc   = r_run_cycles + 1'b1;
  // a zero budget never matches, so the run is unlimited
  assign w_tmo      = r_budget != '0 && w_rc_inc == r_budget;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_next = reload ? S_LOAD : S_HOLD;
      S_LOAD:         if (w_acc && (s_last || w_end_addr)) w_next = S_HOLD;
      S_HOLD:         if (w_hold_end) w_next = S_RUN;
      S_RUN:          if (halt || w_tmo) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_load_count <= '0;
      r_run_cycles <= '0;
      r_budget     <= '0;
      r_hold       <= '0;
      r_overflow   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold  <= r_state == S_HOLD ? r_hold + 1'b1 : '0;
      if (w_go) r_timeout <= 1'b0;
      if (w_go && reload) begin
        r_addr       <= '0;
        r_load_count <= '0;
        r_overflow   <= 1'b0;
        r_run_cycles <= '0;
      end
      if (w_acc) begin
        r_addr       <= r_addr + 1'b1;
        r_load_count <= r_load_count + 1'b1;
        if (w_end_addr && !s_last) r_overflow <= 1'b1;
      end
      if (r_state == S_HOLD && w_hold_end) begin
        r_run_cycles <= '0;
        r_budget     <= budget;
      end
      if (r_state == S_RUN) begin
        r_run_cycles <= &r_run_cycles ? r_run_cycles : w_rc_inc;
        r_timeout    <= !halt && w_tmo;
      end
    end
  end
  assign s_ready    = r_state == S_LOAD;
  assign imem_we    = w_acc;
  assign imem_addr  = r_addr;
  assign imem_wdata = s_data;
  assign core_rst   = r_state != S_RUN;
  assign done       = r_state == S_DONE;
  assign timeout    = r_timeout;
  assign overflow   = r_overflow;
  assign load_count = r_load_count;
  assign run_cycles = r_run_cycles;
endmodule

// File: tb/tb_boot_run_ctrl.sv
// tb_boot_run_ctrl: directed load/hold/run/timeout/overflow/reset checks for boot_run_ctrl
module tb_boot_run_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, reload, s_valid, s_last, halt;
  logic [15:0] budget;
  logic [31:0] s_data;
  logic        s_ready, imem_we, core_rst, done, timeout, overflow;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] load_count;
  logic [15:0] run_cycles;
  logic        start2, reload2, s_valid2, s_last2, halt2;
  logic [15:0] budget2;
  logic [31:0] s_data2;
  logic        s_ready2, imem_we2, core_rst2, done2, timeout2, overflow2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  load_count2;
  logic [15:0] run_cycles2;
  logic [31:0] prog [4];
  int vectors = 0;
  int errs = 0;
  always #5 clk = ~clk;
  boot_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .reload(reload), .budget(budget),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .halt(halt), .done(done), .timeout(timeout),
    .overflow(overflow), .load_count(load_count), .run_cycles(run_cycles)
  );
  boot_run_ctrl #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .reload(reload2), .budget(budget2),
    .s_valid(s_valid2), .s_data(s_data2), .s_last(s_last2), .s_ready(s_ready2),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .core_rst(core_rst2), .halt(halt2), .done(done2), .timeout(timeout2),
    .overflow(overflow2), .load_count(load_count2), .run_cycles(run_cycles2)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    prog[0] = 32'h00500093; prog[1] = 32'h00A00113;
    prog[2] = 32'h002081B3; prog[3] = 32'h00000073;
    rst = 1'b1; start = 0; reload = 0; s_valid = 0; s_last = 0; halt = 0; budget = '0; s_data = '0;
    start2 = 0; reload2 = 0; s_valid2 = 0; s_last2 = 0; halt2 = 0; budget2 = '0; s_data2 = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_run_cycles", run_cycles, 0);
    @(negedge clk) rst = 1'b1;
    tick;
    budget = 16'd100; reload = 1; start = 1;
    tick;
    start = 0;
    chk("load_s_ready", s_ready, 1);
    chk("load_core_rst", core_rst, 1);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = prog[i]; s_last = (i == 3);
      #1;
      chk("load_we", imem_we, 1);
      chk("load_addr", imem_addr, i);
      chk("load_wdata", imem_wdata, prog[i]);
      tick;
    end
    chk("post_load_s_ready", s_ready, 0);
    chk("post_load_we", imem_we, 0);
    chk("load_count4", load_count, 4);
    chk("hold1_core_rst", core_rst, 1);
    s_valid = 0; s_last = 0;
    tick;
    chk("hold2_core_rst", core_rst, 1);
    tick;
    chk("run1_core_rst", core_rst, 0);
    repeat (19) tick;
    chk("run20_done", done, 0);
    chk("run20_cycles", run_cycles, 19);
    halt = 1;
    tick;
    halt = 0;
    chk("halt_done", done, 1);
    chk("halt_timeout", timeout, 0);
    chk("halt_run_cycles", run_cycles, 20);
    chk("halt_core_rst", core_rst, 1);
    budget = 16'd10; reload = 0; start = 1;
    tick;
    start = 0; s_valid = 1;
    #1;
    chk("rerun_we", imem_we, 0);
    chk("rerun_s_ready", s_ready, 0);
    chk("rerun_load_count", load_count, 4);
    chk("rerun_core_rst", core_rst, 1);
    chk("rerun_done", done, 0);
    s_valid = 0;
    tick;
    tick;
    chk("rerun_run_core_rst", core_rst, 0);
    chk("rerun_cycles_clr", run_cycles, 0);
    budget = 16'd3; reload = 1; start = 1;
    tick;
    start = 0;
    chk("run_start_ignored", s_ready, 0);
    chk("run_start_core_rst", core_rst, 0);
    repeat (8) tick;
    chk("tmo_pre_done", done, 0);
    chk("tmo_pre_cycles", run_cycles, 9);
    tick;
    chk("tmo_done", done, 1);
    chk("tmo_timeout", timeout, 1);
    chk("tmo_run_cycles", run_cycles, 10);
    tick;
    chk("tmo_hold_timeout", timeout, 1);
    chk("tmo_hold_cycles", run_cycles, 10);
    budget = 16'd5; reload = 0; start = 1;
    tick;
    start = 0;
    chk("start_clr_timeout", timeout, 0);
    tick;
    tick;
    repeat (4) tick;
    halt = 1;
    tick;
    halt = 0;
    chk("tie_done", done, 1);
    chk("tie_timeout", timeout, 0);
    chk("tie_run_cycles", run_cycles, 5);
    reload2 = 1; start2 = 1;
    tick;
    start2 = 0; s_valid2 = 1;
    for (int i = 0; i < 4; i++) begin
      s_data2 = i + 1;
      #1;
      chk("ovf_we", imem_we2, 1);
      chk("ovf_addr", imem_addr2, i);
      tick;
    end
    chk("ovf_flag", overflow2, 1);
    chk("ovf_s_ready", s_ready2, 0);
    chk("ovf_we5", imem_we2, 0);
    chk("ovf_load_count", load_count2, 4);
    chk("ovf_core_rst", core_rst2, 1);
    tick;
    chk("ovf_we6", imem_we2, 0);
    chk("ovf_sticky", overflow2, 1);
    s_valid2 = 0;
    budget = '0; reload = 0; start = 1;
    tick;
    start = 0;
    tick;
    tick;
    repeat (4) tick;
    chk("mid_run_cycles", run_cycles, 4);
    chk("mid_core_rst", core_rst, 0);
    rst = 1'b0;
    #1;
    chk("arst_core_rst", core_rst, 1);
    chk("arst_done", done, 0);
    chk("arst_run_cycles", run_cycles, 0);
    chk("arst_load_count", load_count, 0);
    chk("arst_overflow2", overflow2, 0);
    tick;
    rst = 1'b1;
    tick;
    s_valid = 1; s_data = 32'hDEADBEEF;
    #1;
    chk("idle_s_ready", s_ready, 0);
    chk("idle_we", imem_we, 0);
    tick;
    s_valid = 0;
    chk("idle_load_count", load_count, 0);
    chk("idle_addr", imem_addr, 0);
    chk("idle_core_rst", core_rst, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
